tone_player: RTL and testbench

- Audio back end for game sound effects. Sits directly downstream of sinewaver.
- Generates sinewaver's trigger pulses at a programmable pitch, and holds sinewaver in phase reset at note start.
- Consumes sinewaver's 16-bit offset-binary waveform, applies a 2-bit volume and drives a 1-bit speaker pin through a first-order sigma-delta modulator.
- Plays one timed note per play request, then drains to a rising midpoint crossing before going idle, to avoid clicks.

---
 rtl/tone_player.sv | 188 ++++++++++++++++++
 tb/tb_tone_player.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tone_player.sv
// ---------------------------------------------------------------------------
// tone_player
//   Audio back end placed directly after sinewaver. Each accepted play
//   request restarts the sine phase (wave_rst), produces trigger pulses at
//   the latched pitch for `duration` cycles, then keeps triggering until the
//   waveform makes a rising midpoint crossing (or a trigger budget runs out)
//   so the note ends without a click. The returned waveform is scaled by a
//   2-bit volume and turned into a 1-bit speaker stream by a first-order
//   sigma-delta modulator.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   play      in   start request, honoured only while busy=0
//   pitch     in   [15:0] trigger period minus 1, latched on acceptance
//   duration  in   [DUR_W-1:0] note length in cycles, latched on acceptance
//   volume    in   [1:0] 0=mute 1=quarter 2=half 3=full (live)
//   wave_in   in   [15:0] offset-binary sample from sinewaver
//   wave_rst  out  one-cycle phase restart pulse to sinewaver
//   trigger   out  one-cycle step pulses to sinewaver
//   busy      out  high while playing or draining
//   done      out  one-cycle pulse on return to idle
//   audio     out  sigma-delta speaker bit
// ---------------------------------------------------------------------------
module tone_player #(
  parameter int DUR_W     = 24,
  parameter int DRAIN_MAX = 2047
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             play,
  input  logic [15:0]      pitch,
  input  logic [DUR_W-1:0] duration,
  input  logic [1:0]       volume,
  input  logic [15:0]      wave_in,
  output logic             wave_rst,
  output logic             trigger,
  output logic             busy,
  output logic             done,
  output logic             audio
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int DRN_W = $clog2(DRAIN_MAX + 1);
  localparam logic [DRN_W:0] DRAIN_LIM = DRAIN_MAX[DRN_W:0];

  logic [1:0]       state_q,    state_d;
  logic [15:0]      pitch_q,    pitch_d;
  logic [15:0]      div_q,      div_d;
  logic [DUR_W-1:0] dur_q,      dur_d;
  logic [DRN_W-1:0] drain_q,    drain_d;
  logic             prev_msb_q, prev_msb_d;
  logic             wave_rst_q, wave_rst_d;
  logic             trigger_q,  trigger_d;
  logic             done_q,     done_d;
  logic [15:0]      u_q,        u_d;
  logic [16:0]      acc_q,      acc_d;

  logic             busy_now;
  logic             fire;
  logic             crossing;
  logic [DRN_W:0]   drain_sum;
  logic signed [15:0] s_val;
  logic signed [15:0] scaled;

  assign busy_now = (state_q != ST_IDLE);

  // Control: FSM, trigger divider, duration and drain counters.
  always_comb begin
    state_d    = state_q;
    pitch_d    = pitch_q;
    div_d      = div_q;
    dur_d      = dur_q;
    drain_d    = drain_q;
    prev_msb_d = wave_in[15];
    wave_rst_d = 1'b0;
    trigger_d  = 1'b0;
    done_d     = 1'b0;
    fire       = 1'b0;

    // The divider free-runs only while a note is active.
    if (busy_now) begin
      if (div_q == 16'd0) begin
        fire  = 1'b1;
        div_d = pitch_q;
      end else begin
        div_d = div_q - 16'd1;
      end
    end

    // Triggers already visible on the output during DRAIN count toward the
    // forced-stop budget, including the one shown this cycle.
    drain_sum = {1'b0, drain_q} + {{DRN_W{1'b0}}, trigger_q};
    crossing  = !prev_msb_q && wave_in[15];

    case (state_q)
      ST_IDLE: begin
        if (play) begin
          state_d    = ST_PLAY;
          pitch_d    = pitch;
          div_d      = pitch;
          dur_d      = duration;
          drain_d    = '0;
          wave_rst_d = 1'b1;
          // Masks any stale low sample so a crossing cannot be seen early.
          prev_msb_d = 1'b1;
        end
      end
      ST_PLAY: begin
        trigger_d = fire;
        if (dur_q == '0) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          dur_d = dur_q - DUR_W'(1);
        end
      end
      ST_DRAIN: begin
        drain_d = drain_sum[DRN_W-1:0];
        if (crossing || (drain_sum == DRAIN_LIM)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          // No trigger may appear once the block is back in idle.
          trigger_d = 1'b0;
        end else begin
          trigger_d = fire;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sample path: remove offset, arithmetic-shift for volume, restore offset.
  always_comb begin
    s_val = wave_in ^ 16'h8000;
    case (volume)
      2'd3:    scaled = s_val;
      2'd2:    scaled = s_val >>> 1;
      2'd1:    scaled = s_val >>> 2;
      default: scaled = 16'sd0;
    endcase
    u_d = busy_now ? (16'(scaled) ^ 16'h8000) : 16'h8000;
  end

  // The carry out of the 16-bit accumulator is the speaker bit.
  assign acc_d = {1'b0, acc_q[15:0]} + {1'b0, u_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pitch_q    <= '0;
      div_q      <= '0;
      dur_q      <= '0;
      drain_q    <= '0;
      prev_msb_q <= 1'b1;
      wave_rst_q <= 1'b0;
      trigger_q  <= 1'b0;
      done_q     <= 1'b0;
      // Idle midpoint so the modulator settles into a 50% pattern at once.
      u_q        <= 16'h8000;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      pitch_q    <= pitch_d;
      div_q      <= div_d;
      dur_q      <= dur_d;
      drain_q    <= drain_d;
      prev_msb_q <= prev_msb_d;
      wave_rst_q <= wave_rst_d;
      trigger_q  <= trigger_d;
      done_q     <= done_d;
      u_q        <= u_d;
      acc_q      <= acc_d;
    end
  end

  assign wave_rst = wave_rst_q;
  assign trigger  = trigger_q;
  assign done     = done_q;
  assign busy     = busy_now;
  assign audio    = acc_q[16];

endmodule

// File: tb/tb_tone_player.sv
// ---------------------------------------------------------------------------
// tb_tone_player
//   Scoreboard bench for tone_player. The stimulus process plans each note
//   (pitch, duration, the full wave_in sequence), predicts from the
//   behavioural rules the cycles of wave_rst, every trigger and done, and
//   queues them. A monitor pops and compares whenever the DUT pulses one of
//   those outputs. Audio ones-density is checked over exact windows.
// ---------------------------------------------------------------------------
module tb_tone_player;

  localparam int DUR_W     = 24;
  localparam int DRAIN_MAX = 2047;
  localparam int NOCUT     = 1 << 30;
  localparam int WMAX      = 20000;

  logic             clk = 1'b0;
  logic             rst;
  logic             play;
  logic [15:0]      pitch;
  logic [DUR_W-1:0] duration;
  logic [1:0]       volume;
  logic [15:0]      wave_in;
  logic             wave_rst, trigger, busy, done, audio;

  tone_player #(.DUR_W(DUR_W), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .play     (play),
    .pitch    (pitch),
    .duration (duration),
    .volume   (volume),
    .wave_in  (wave_in),
    .wave_rst (wave_rst),
    .trigger  (trigger),
    .busy     (busy),
    .done     (done),
    .audio    (audio)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int ones_cnt = 0;
  logic busy_prev = 1'b0;

  int exp_rst[$];
  int exp_trig[$];
  int exp_done[$];

  logic [15:0] wv [0:WMAX-1];
  int wv_len = 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [15:0] wget(input int t);
    return wv[(t < wv_len) ? t : (wv_len - 1)];
  endfunction

  // Monitor: compare every output pulse against the planned event queues.
  always @(negedge clk) begin
    if (audio === 1'b1) ones_cnt++;
    if (wave_rst === 1'b1) begin
      if (exp_rst.size() == 0) chk("wave_rst_unexpected", cyc, -1);
      else chk("wave_rst_cycle", cyc, exp_rst.pop_front());
      chk("busy_at_wave_rst", int'(busy), 1);
    end
    if (trigger === 1'b1) begin
      if (exp_trig.size() == 0) chk("trigger_unexpected", cyc, -1);
      else chk("trigger_cycle", cyc, exp_trig.pop_front());
    end
    if (done === 1'b1) begin
      if (exp_done.size() == 0) chk("done_unexpected", cyc, -1);
      else chk("done_cycle", cyc, exp_done.pop_front());
      chk("busy_at_done", int'(busy), 0);
      chk("busy_before_done", int'(busy_prev), 1);
    end
    busy_prev = busy;
  end

  // Reference rules: trigger every (P+1) cycles after acceptance; DRAIN
  // begins D+1 cycles after acceptance; the note ends after the first cycle
  // in DRAIN that shows a rising msb edge or the DRAIN_MAX-th DRAIN trigger.
  // A reset at relative cycle `cut` discards everything after it.
  task automatic predict(input int c0, input int p, input int d, input int cut,
                         output int t_stop);
    int dcnt;
    bit trig;
    dcnt   = 0;
    t_stop = cut;
    exp_rst.push_back(c0);
    for (int t = 1; t < 10_000_000; t++) begin
      if (t > cut) begin
        t_stop = cut;
        return;
      end
      trig = ((t % (p + 1)) == 0);
      if (trig) exp_trig.push_back(c0 + t);
      if (t >= d + 1) begin
        if (trig) dcnt++;
        if ((!wget(t - 1)[15] && wget(t)[15]) || (dcnt == DRAIN_MAX)) begin
          if (t + 1 <= cut) exp_done.push_back(c0 + t + 1);
          t_stop = (t + 1 <= cut) ? t + 1 : cut;
          return;
        end
      end
    end
  endtask

  // mode 1: a second play with another pitch mid-note (must be ignored)
  // mode 2: step volume 3..0 and measure audio density in each step
  task automatic run_note(input int p, input int d, input int cut, input int mode);
    int c0, t_stop, o_start, sv, expu;
    play     = 1'b1;
    pitch    = 16'(p);
    duration = DUR_W'(d);
    c0       = cyc + 1;
    o_start  = 0;
    predict(c0, p, d, cut, t_stop);
    for (int t = 0; t <= t_stop; t++) begin
      @(posedge clk); #1;
      play    = 1'b0;
      wave_in = wget(t);
      if (mode == 1 && t == 10) begin
        play  = 1'b1;
        pitch = 16'd7;
      end
      if (mode == 2) begin
        for (int k = 0; k < 4; k++) begin
          if (t == 200 + k * 4200) volume = 2'(3 - k);
          if (t == 220 + k * 4200) o_start = ones_cnt;
          if (t == 220 + k * 4200 + 4096) begin
            sv   = int'(wget(t)) - 32768;
            expu = ((3 - k) == 0) ? 32768 : (sv >>> k) + 32768;
            chk($sformatf("audio_ones_vol%0d", 3 - k), ones_cnt - o_start, expu / 16);
          end
        end
      end
      if (t == cut) rst = 1'b1;
    end
    if (cut < NOCUT) begin
      @(posedge clk); #1;
      chk("busy_after_rst", int'(busy), 0);
      chk("done_after_rst", int'(done), 0);
      rst = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("pending_wave_rst", exp_rst.size(), 0);
    chk("pending_trigger", exp_trig.size(), 0);
    chk("pending_done", exp_done.size(), 0);
    chk("busy_idle", int'(busy), 0);
    exp_rst.delete();
    exp_trig.delete();
    exp_done.delete();
  endtask

  initial begin
    int o0;
    rst      = 1'b1;
    play     = 1'b0;
    pitch    = '0;
    duration = '0;
    volume   = 2'd3;
    wave_in  = 16'h8000;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_wave_rst", int'(wave_rst), 0);
    chk("rst_trigger", int'(trigger), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_audio", int'(audio), 0);
    rst = 1'b0;

    // Idle: midpoint tone, exactly half ones over 100 cycles.
    repeat (5) @(posedge clk);
    #1;
    o0 = ones_cnt;
    repeat (100) @(posedge clk);
    #1;
    chk("idle_audio_ones", ones_cnt - o0, 50);

    // Flat midpoint wave: no crossing, forced stop after DRAIN_MAX triggers.
    wv_len = 1; wv[0] = 16'h8000;
    run_note(3, 40, NOCUT, 0);

    // Crossing in DRAIN, plus an ignored play while busy.
    wv_len = 62;
    for (int i = 0; i < 60; i++) wv[i] = 16'h8000;
    wv[60] = 16'h7000;
    wv[61] = 16'h9000;
    run_note(3, 40, NOCUT, 1);

    // Boundary: pitch 0 and duration 0, forced stop.
    wv_len = 1; wv[0] = 16'h8000;
    run_note(0, 0, NOCUT, 0);

    // Volume steps on a static 0xC000 sample, ended by a reset mid-note.
    wv_len = 1; wv[0] = 16'hC000;
    run_note(99, 20000, 17500, 2);

    // Randomised notes with random waveforms.
    for (int n = 0; n < 10; n++) begin
      wv_len = 400;
      for (int i = 0; i < 400; i++) wv[i] = 16'($urandom);
      volume = 2'($urandom_range(0, 3));
      run_note(int'($urandom_range(0, 5)), int'($urandom_range(0, 30)), NOCUT, 0);
    end

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
